// File: rtl/sales_pkg.sv
// Shared types and default sizing for the sales statistics block.
// Holds the controller state encoding used by sales_stats.
package sales_pkg;

    localparam int W_DEF    = 32;
    localparam int CH_DEF   = 4;
    localparam int ACCW_DEF = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/sales_if.sv
// Transaction in / result out bundle between a producer and sales_stats.
// The master side offers transactions and consumes results.
interface sales_if #(
    parameter int W  = 32,
    parameter int CH = 4
);
    localparam int CHW = $clog2(CH);

    logic           in_valid;
    logic           in_ready;
    logic [CHW-1:0] in_ch;
    logic [W-1:0]   price;
    logic [W-1:0]   num;
    logic           out_valid;
    logic [CHW-1:0] out_ch;
    logic [W-1:0]   avg;
    logic [CH-1:0]  ovf;

    modport master (
        output in_valid, in_ch, price, num,
        input  in_ready, out_valid, out_ch, avg, ovf
    );

    modport slave (
        input  in_valid, in_ch, price, num,
        output in_ready, out_valid, out_ch, avg, ovf
    );
endinterface

// File: rtl/sales_div.sv
// Restoring unsigned divider, one quotient bit per cycle, ACCW cycles per divide.
// quotient is valid in the cycle done is high; a zero divisor yields 0.
module sales_div #(
    parameter int ACCW = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [ACCW-1:0] dividend,
    input  logic [ACCW-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [ACCW-1:0] quotient
);
    localparam int CW = $clog2(ACCW + 1);

    logic [ACCW-1:0] rem_reg, quo_reg, dvs_reg;
    logic [CW-1:0]   cnt_reg;
    logic            busy_reg;

    logic [ACCW:0]   shifted, trial;
    logic            bit_ok;
    logic [ACCW-1:0] rem_next, quo_next;

    always_comb begin
        shifted  = {rem_reg, quo_reg[ACCW-1]};
        trial    = shifted - {1'b0, dvs_reg};
        // Remainder stays below the divisor, so the MSB of trial is the borrow.
        bit_ok   = ~trial[ACCW];
        rem_next = bit_ok ? trial[ACCW-1:0] : shifted[ACCW-1:0];
        quo_next = {quo_reg[ACCW-2:0], bit_ok};
    end

    assign busy     = busy_reg;
    assign done     = busy_reg && (cnt_reg == CW'(ACCW - 1));
    assign quotient = (dvs_reg == '0) ? '0 : quo_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_reg  <= '0;
            quo_reg  <= '0;
            dvs_reg  <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
        end else if (start) begin
            rem_reg  <= '0;
            quo_reg  <= dividend;
            dvs_reg  <= divisor;
            cnt_reg  <= '0;
            busy_reg <= 1'b1;
        end else if (busy_reg) begin
            rem_reg  <= rem_next;
            quo_reg  <= quo_next;
            cnt_reg  <= cnt_reg + 1'b1;
            if (done) begin
                busy_reg <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/sales_stats.sv
// Per-channel revenue/quantity accumulators with a weighted-average price result.
// Each accepted transaction updates one channel, then divides rev by qty.
module sales_stats
    import sales_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int CH   = CH_DEF,
    parameter int ACCW = ACCW_DEF
) (
    input  logic    clk,
    input  logic    rst,
    sales_if.slave  bus
);
    localparam int CHW = $clog2(CH);

    state_t state_reg, state_next;

    logic [CHW-1:0]  ch_reg;
    logic [W-1:0]    price_reg, num_reg;
    logic [W-1:0]    avg_reg;
    logic [CHW-1:0]  out_ch_reg;
    logic [CH-1:0]   ovf_reg;
    logic [ACCW-1:0] rev_reg [CH];
    logic [ACCW-1:0] qty_reg [CH];

    logic            acc_en, div_start, div_busy, div_done;
    logic [ACCW-1:0] div_quot;
    logic [CH-1:0]   ch_hit;
    logic [2*W-1:0]  prod;
    logic [ACCW:0]   rev_sum, qty_sum;
    logic            accept;

    assign accept = (state_reg == IDLE) && bus.in_valid;

    always_comb begin
        state_next = state_reg;
        acc_en     = 1'b0;
        div_start  = 1'b0;
        case (state_reg)
            IDLE: if (bus.in_valid) state_next = ACC;
            ACC: begin
                acc_en     = 1'b1;
                div_start  = 1'b1;
                state_next = DIV;
            end
            DIV:  if (div_done) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_reg    <= '0;
            price_reg <= '0;
            num_reg   <= '0;
        end else if (accept) begin
            ch_reg    <= bus.in_ch;
            price_reg <= bus.price;
            num_reg   <= bus.num;
        end
    end

    // Sums are formed on the selected channel and also feed the divider directly,
    // so the divide starts from the post-update totals.
    assign prod    = {{W{1'b0}}, price_reg} * {{W{1'b0}}, num_reg};
    assign rev_sum = {1'b0, rev_reg[ch_reg]} + {1'b0, ACCW'(prod)};
    assign qty_sum = {1'b0, qty_reg[ch_reg]} + {1'b0, ACCW'(num_reg)};

    for (genvar gi = 0; gi < CH; gi++) begin : g_hit
        assign ch_hit[gi] = acc_en && (ch_reg == CHW'(gi));
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < CH; i++) begin
            if (rst) begin
                rev_reg[i] <= '0;
                qty_reg[i] <= '0;
                ovf_reg[i] <= 1'b0;
            end else if (ch_hit[i]) begin
                rev_reg[i] <= rev_sum[ACCW-1:0];
                qty_reg[i] <= qty_sum[ACCW-1:0];
                if (rev_sum[ACCW] || qty_sum[ACCW]) begin
                    ovf_reg[i] <= 1'b1;
                end
            end
        end
    end

    sales_div #(.ACCW(ACCW)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (rev_sum[ACCW-1:0]),
        .divisor  (qty_sum[ACCW-1:0]),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            avg_reg    <= '0;
            out_ch_reg <= '0;
        end else if (state_reg == DIV && div_done) begin
            avg_reg    <= div_quot[W-1:0];
            out_ch_reg <= ch_reg;
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.out_ch    = out_ch_reg;
    assign bus.avg       = avg_reg;
    assign bus.ovf       = ovf_reg;
endmodule
